// File: rtl/mac_ctrl_pkg.sv
// Shared types and default geometry for the MAC array controller.
package mac_ctrl_pkg;

    localparam int DEF_ARRAY_HEIGHT = 4;
    localparam int DEF_ARRAY_WIDTH  = 4;
    localparam int DEF_NUM_WIDTH    = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/mac_array_ctrl_if.sv
// Job handshake plus weight/ifmap/ofmap buffer controls of the MAC array controller.
interface mac_array_ctrl_if
    import mac_ctrl_pkg::*;
#(
    parameter int ARRAY_HEIGHT = DEF_ARRAY_HEIGHT,
    parameter int NUM_WIDTH    = DEF_NUM_WIDTH
) ();

    localparam int WADDR_W = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;

    logic                    start;
    logic [NUM_WIDTH-1:0]    num_vectors;
    logic                    stall;
    logic [WADDR_W-1:0]      weight_rd_addr;
    logic [ARRAY_HEIGHT-1:0] weight_write_enable;
    logic                    enable;
    logic                    ifmap_rd_en;
    logic [NUM_WIDTH-1:0]    ifmap_rd_addr;
    logic                    ofmap_wr_en;
    logic [NUM_WIDTH-1:0]    ofmap_wr_addr;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, num_vectors, stall,
        output weight_rd_addr, weight_write_enable, enable,
        output ifmap_rd_en, ifmap_rd_addr, ofmap_wr_en, ofmap_wr_addr,
        output busy, done
    );

    modport slave (
        output start, num_vectors, stall,
        input  weight_rd_addr, weight_write_enable, enable,
        input  ifmap_rd_en, ifmap_rd_addr, ofmap_wr_en, ofmap_wr_addr,
        input  busy, done
    );

endinterface

// File: rtl/mac_step_counter.sv
// Streaming step counter: cleared outside the streaming phases, advances only on
// unstalled steps so a stall holds every derived address.
module mac_step_counter #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // count register with clear priority over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= WIDTH'(0);
        end else if (clr) begin
            count_r <= WIDTH'(0);
        end else if (inc) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/mac_array_ctrl.sv
// MAC array controller: loads one weight row per cycle, then streams N ifmap vectors
// through the array and collects N ofmap results once the pipeline depth has elapsed.
module mac_array_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int ARRAY_HEIGHT = DEF_ARRAY_HEIGHT,
    parameter int ARRAY_WIDTH  = DEF_ARRAY_WIDTH,
    parameter int NUM_WIDTH    = DEF_NUM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    mac_array_ctrl_if.master bus
);

    localparam int WADDR_W = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam int S_W     = NUM_WIDTH + 1;
    // one extra bit so N + depth never overflows in comparisons
    localparam int C_W     = NUM_WIDTH + 2;
    localparam int DEPTH   = ARRAY_HEIGHT + ARRAY_WIDTH - 1;

    localparam logic [C_W-1:0]     DEPTH_C  = C_W'(DEPTH);
    localparam logic [WADDR_W-1:0] LAST_ROW = WADDR_W'(ARRAY_HEIGHT - 1);

    state_e               state_r;
    state_e               state_next_s;
    logic [NUM_WIDTH-1:0] n_r;
    logic [WADDR_W-1:0]   row_r;
    logic [S_W-1:0]       step_cnt_s;
    logic                 in_step_phase_s;
    logic                 step_s;
    logic                 wr_window_s;
    logic [C_W-1:0]       s_ext_s;
    logic [C_W-1:0]       n_ext_s;
    logic [C_W-1:0]       last_in_s;
    logic [C_W-1:0]       last_out_s;

    assign s_ext_s         = C_W'(step_cnt_s);
    assign n_ext_s         = C_W'(n_r);
    assign last_in_s       = n_ext_s - C_W'(1);
    assign last_out_s      = n_ext_s + DEPTH_C - C_W'(1);
    assign in_step_phase_s = (state_r == ST_STREAM) || (state_r == ST_DRAIN);
    assign step_s          = in_step_phase_s && !bus.stall;
    assign wr_window_s     = (s_ext_s >= DEPTH_C) && (s_ext_s < (n_ext_s + DEPTH_C));

    mac_step_counter #(
        .WIDTH (S_W)
    ) u_step_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (!in_step_phase_s),
        .inc   (step_s),
        .count (step_cnt_s)
    );

    // state register, job-size capture and weight-row counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            n_r     <= NUM_WIDTH'(0);
            row_r   <= WADDR_W'(0);
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_IDLE) && bus.start) begin
                n_r <= bus.num_vectors;
            end else begin
                n_r <= n_r;
            end
            if ((state_r == ST_LOAD_W) && (row_r != LAST_ROW)) begin
                row_r <= row_r + WADDR_W'(1);
            end else begin
                row_r <= WADDR_W'(0);
            end
        end
    end

    // next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_next_s = ST_LOAD_W;
                else           state_next_s = ST_IDLE;
            end
            ST_LOAD_W: begin
                if (row_r != LAST_ROW)            state_next_s = ST_LOAD_W;
                else if (n_r == NUM_WIDTH'(0))    state_next_s = ST_DONE;
                else                              state_next_s = ST_STREAM;
            end
            ST_STREAM: begin
                if (step_s && (s_ext_s == last_in_s)) state_next_s = ST_DRAIN;
                else                                  state_next_s = ST_STREAM;
            end
            ST_DRAIN: begin
                if (step_s && (s_ext_s == last_out_s)) state_next_s = ST_DONE;
                else                                   state_next_s = ST_DRAIN;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // output decode from registered state/counters, gated by stall
    always_comb begin
        bus.busy                = (state_r != ST_IDLE);
        bus.done                = (state_r == ST_DONE);
        bus.enable              = step_s;
        bus.weight_rd_addr      = WADDR_W'(0);
        bus.weight_write_enable = ARRAY_HEIGHT'(0);
        bus.ifmap_rd_en         = 1'b0;
        bus.ifmap_rd_addr       = NUM_WIDTH'(0);
        bus.ofmap_wr_en         = step_s && wr_window_s;
        bus.ofmap_wr_addr       = NUM_WIDTH'(0);
        if (state_r == ST_LOAD_W) begin
            bus.weight_rd_addr      = row_r;
            bus.weight_write_enable = ARRAY_HEIGHT'(1) << row_r;
        end else begin
            bus.weight_rd_addr      = WADDR_W'(0);
            bus.weight_write_enable = ARRAY_HEIGHT'(0);
        end
        if (state_r == ST_STREAM) begin
            bus.ifmap_rd_en   = !bus.stall;
            bus.ifmap_rd_addr = NUM_WIDTH'(step_cnt_s);
        end else begin
            bus.ifmap_rd_en   = 1'b0;
            bus.ifmap_rd_addr = NUM_WIDTH'(0);
        end
        if (wr_window_s) begin
            bus.ofmap_wr_addr = NUM_WIDTH'(s_ext_s - DEPTH_C);
        end else begin
            bus.ofmap_wr_addr = NUM_WIDTH'(0);
        end
    end

endmodule
